simon_kexp_sched: RTL and testbench

Arbiter and sequencer that shares one `simon_kexp` key expander between two requesters (e.g. an encrypt core and a decrypt core). It selects a requester round-robin, clears and loads the expander, waits for expansion to finish, then grants that requester ownership of the expanded-key bus until it releases it. An optional single-entry key cache skips re-expansion when the same mode and key are requested again.

---
 rtl/simon_kexp_sched_if.sv | 27 ++
 rtl/simon_kexp_sched.sv | 137 +++++++++++++
 tb/tb_simon_kexp_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_kexp_sched_if.sv
// Requester and key-expander signal bundle for simon_kexp_sched.
// The slave modport is the scheduler; the master modport is the surrounding requesters/expander.
interface simon_kexp_sched_if #(
  parameter int SIMON_KEY_WIDTH = 128
);
  logic [1:0]                 rq_valid;
  logic [1:0]                 rq_mode;
  logic [SIMON_KEY_WIDTH-1:0] rq_key0;
  logic [SIMON_KEY_WIDTH-1:0] rq_key1;
  logic [1:0]                 rq_grant;
  logic                       kx_nrst;
  logic                       kx_mode;
  logic [SIMON_KEY_WIDTH-1:0] kx_key;
  logic                       kx_valid;
  logic                       kx_ready;
  logic                       kx_exp_valid;

  modport master (
    output rq_valid, rq_mode, rq_key0, rq_key1, kx_ready, kx_exp_valid,
    input  rq_grant, kx_nrst, kx_mode, kx_key, kx_valid
  );

  modport slave (
    input  rq_valid, rq_mode, rq_key0, rq_key1, kx_ready, kx_exp_valid,
    output rq_grant, kx_nrst, kx_mode, kx_key, kx_valid
  );
endinterface

// File: rtl/simon_kexp_sched.sv
// Round-robin arbiter/sequencer sharing one simon_kexp key expander between two requesters.
// Define SIMON_KSCHED_CACHE_EN to add a single-entry {mode, key} cache that skips re-expansion.
//
// state   | meaning
// IDLE    | arbitrate between pending requesters, latch key/mode
// CLR     | kx_nrst low for one cycle to return the expander to idle
// LOAD    | kx_valid high until the expander accepts the key
// WAIT    | expansion running, wait for kx_exp_valid
// GRANT   | owner holds the expanded-key bus until it drops rq_valid
module simon_kexp_sched #(
  parameter int SIMON_KEY_WIDTH = 128,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 ck,
  input  logic                 nrst,
  simon_kexp_sched_if.slave    bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] exp_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_WAIT,
    S_GRANT
  } state_t;

  state_t                     state;
  logic                       owner;
  logic                       last;
  logic                       sel;
  logic                       sel_mode;
  logic [SIMON_KEY_WIDTH-1:0] sel_key;
  logic                       hit;

  always_comb begin
    sel      = (bus.rq_valid == 2'b11) ? ~last : bus.rq_valid[1];
    sel_key  = sel ? bus.rq_key1 : bus.rq_key0;
    sel_mode = bus.rq_mode[sel];
  end

`ifdef SIMON_KSCHED_CACHE_EN
  logic                       tag_valid;
  logic                       tag_mode;
  logic [SIMON_KEY_WIDTH-1:0] tag_key;

  // Tag tracks what the expander currently holds; reset clears both together.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      tag_valid <= 1'b0;
      tag_mode  <= 1'b0;
      tag_key   <= '0;
    end else if (state == S_WAIT && bus.kx_exp_valid) begin
      tag_valid <= 1'b1;
      tag_mode  <= bus.kx_mode;
      tag_key   <= bus.kx_key;
    end
  end

  assign hit = tag_valid && (tag_mode == sel_mode) && (tag_key == sel_key);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      bus.rq_grant <= 2'b00;
      bus.kx_nrst  <= 1'b0;
      bus.kx_valid <= 1'b0;
      bus.kx_mode  <= 1'b0;
      bus.kx_key   <= '0;
      busy         <= 1'b0;
      exp_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rq_valid != 2'b00) begin
            owner       <= sel;
            last        <= sel;
            bus.kx_key  <= sel_key;
            bus.kx_mode <= sel_mode;
            busy        <= 1'b1;
            if (hit) begin
              state        <= S_GRANT;
              bus.rq_grant <= sel ? 2'b10 : 2'b01;
            end else begin
              state       <= S_CLR;
              bus.kx_nrst <= 1'b0;
            end
          end
        end
        S_CLR: begin
          state        <= S_LOAD;
          bus.kx_nrst  <= 1'b1;
          bus.kx_valid <= 1'b1;
        end
        S_LOAD: begin
          if (bus.kx_ready) begin
            state        <= S_WAIT;
            bus.kx_valid <= 1'b0;
            if (exp_count != '1) exp_count <= exp_count + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.kx_exp_valid) begin
            if (bus.rq_valid[owner]) begin
              state        <= S_GRANT;
              bus.rq_grant <= owner ? 2'b10 : 2'b01;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        S_GRANT: begin
          // No preemption: only the owner's release ends the grant.
          if (!bus.rq_valid[owner]) begin
            state        <= S_IDLE;
            bus.rq_grant <= 2'b00;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.rq_grant <= 2'b00;
          bus.kx_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_kexp_sched.sv
// Directed bench for simon_kexp_sched with a small behavioural expander model per DUT.
// Expectations adapt to SIMON_KSCHED_CACHE_EN at compile time.
module tb_simon_kexp_sched;

  localparam logic [127:0] K1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] K2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] K3 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  localparam logic [127:0] K4 = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic        ck = 1'b0;
  logic        nrst;
  logic        busy_a;
  logic [15:0] cnt_a;
  logic        busy_s;
  logic [3:0]  cnt_s;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          exp_cnt = 0;

  always #5 ck = ~ck;

  simon_kexp_sched_if #(.SIMON_KEY_WIDTH(128)) bus ();
  simon_kexp_sched_if #(.SIMON_KEY_WIDTH(128)) bus_s ();

  simon_kexp_sched #(.SIMON_KEY_WIDTH(128), .CNT_WIDTH(16)) u_dut (
    .ck(ck), .nrst(nrst), .bus(bus), .busy(busy_a), .exp_count(cnt_a)
  );

  simon_kexp_sched #(.SIMON_KEY_WIDTH(128), .CNT_WIDTH(4)) u_sat (
    .ck(ck), .nrst(nrst), .bus(bus_s), .busy(busy_s), .exp_count(cnt_s)
  );

  // Expander model: ready when idle, exp_valid a few cycles after accept, held until kx_nrst.
  logic [2:0] ma_cnt, mb_cnt;
  logic       ma_busy, ma_done, mb_busy, mb_done;

  always @(posedge ck) begin
    if (!bus.kx_nrst) begin
      ma_busy <= 1'b0; ma_done <= 1'b0; ma_cnt <= 3'd0;
    end else if (!ma_busy && !ma_done && bus.kx_valid) begin
      ma_busy <= 1'b1; ma_cnt <= 3'd3;
    end else if (ma_busy) begin
      if (ma_cnt == 3'd0) begin ma_busy <= 1'b0; ma_done <= 1'b1; end
      else ma_cnt <= ma_cnt - 3'd1;
    end
  end

  always @(posedge ck) begin
    if (!bus_s.kx_nrst) begin
      mb_busy <= 1'b0; mb_done <= 1'b0; mb_cnt <= 3'd0;
    end else if (!mb_busy && !mb_done && bus_s.kx_valid) begin
      mb_busy <= 1'b1; mb_cnt <= 3'd1;
    end else if (mb_busy) begin
      if (mb_cnt == 3'd0) begin mb_busy <= 1'b0; mb_done <= 1'b1; end
      else mb_cnt <= mb_cnt - 3'd1;
    end
  end

  assign bus.kx_ready       = !ma_busy && !ma_done;
  assign bus.kx_exp_valid   = ma_done;
  assign bus_s.kx_ready     = !mb_busy && !mb_done;
  assign bus_s.kx_exp_valid = mb_done;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Edge T samples the request, CLR pulse, LOAD, accept at T+2.
  task automatic miss_flow(input string tag, input logic [127:0] key);
    tick();
    chk({tag, "_clr_nrst"}, bus.kx_nrst, 0);
    chk({tag, "_busy"}, busy_a, 1);
    chk({tag, "_key"}, bus.kx_key, key);
    tick();
    chk({tag, "_load_nrst"}, bus.kx_nrst, 1);
    chk({tag, "_load_valid"}, bus.kx_valid, 1);
    tick();
    exp_cnt++;
    chk({tag, "_accept_valid"}, bus.kx_valid, 0);
    chk({tag, "_count"}, cnt_a, exp_cnt);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int c = 0; c < 40 && bus.rq_grant == 2'b00; c++) tick();
    chk(tag, bus.rq_grant, exp);
  endtask

  initial begin
    logic saw_grant;
    nrst = 1'b0;
    bus.rq_valid = 2'b00; bus.rq_mode = 2'b00; bus.rq_key0 = '0; bus.rq_key1 = '0;
    bus_s.rq_valid = 2'b00; bus_s.rq_mode = 2'b00; bus_s.rq_key0 = '0; bus_s.rq_key1 = '0;
    tick(); tick();
    chk("rst_grant", bus.rq_grant, 0);
    chk("rst_kx_nrst", bus.kx_nrst, 0);
    chk("rst_kx_valid", bus.kx_valid, 0);
    chk("rst_kx_key", bus.kx_key, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", cnt_a, 0);
    nrst = 1'b1;
    tick();

    // Requester 0, 64_128 miss.
    bus.rq_key0 = K1; bus.rq_mode = 2'b00; bus.rq_valid = 2'b01;
    miss_flow("r0_first", K1);
    wait_grant("r0_first_grant", 2'b01);
    chk("r0_first_mode", bus.kx_mode, 0);
    bus.rq_valid = 2'b00;
    tick();
    chk("r0_release_grant", bus.rq_grant, 0);
    chk("r0_release_busy", busy_a, 0);

    // Requester 1, same key and mode.
    bus.rq_key1 = K1; bus.rq_valid = 2'b10;
`ifdef SIMON_KSCHED_CACHE_EN
    tick();
    chk("r1_hit_grant", bus.rq_grant, 2'b10);
    chk("r1_hit_count", cnt_a, exp_cnt);
`else
    miss_flow("r1_same", K1);
    wait_grant("r1_same_grant", 2'b10);
`endif
    bus.rq_valid = 2'b00;
    tick();

    // Simultaneous pair, 128_128: requester 0 wins, no preemption.
    bus.rq_key0 = K2; bus.rq_key1 = K3; bus.rq_mode = 2'b11; bus.rq_valid = 2'b11;
    miss_flow("pair1_r0", K2);
    wait_grant("pair1_r0_grant", 2'b01);
    tick(); tick();
    chk("pair1_hold", bus.rq_grant, 2'b01);
    bus.rq_valid = 2'b10;
    tick();
    chk("pair1_r0_rel", bus.rq_grant, 0);
    miss_flow("pair1_r1", K3);
    wait_grant("pair1_r1_grant", 2'b10);
    bus.rq_valid = 2'b00;
    tick();

    // Requester 0 drops during WAIT.
    bus.rq_key0 = K4; bus.rq_mode = 2'b00; bus.rq_valid = 2'b01;
    miss_flow("drop", K4);
    bus.rq_valid = 2'b00;
    saw_grant = 1'b0;
    for (int c = 0; c < 20 && busy_a; c++) begin
      tick();
      if (bus.rq_grant != 2'b00) saw_grant = 1'b1;
    end
    chk("drop_no_grant", saw_grant, 0);
    chk("drop_idle", busy_a, 0);
    bus.rq_valid = 2'b01;
`ifdef SIMON_KSCHED_CACHE_EN
    tick();
    chk("drop_rehit_grant", bus.rq_grant, 2'b01);
    chk("drop_rehit_count", cnt_a, exp_cnt);
`else
    miss_flow("drop_re", K4);
    wait_grant("drop_re_grant", 2'b01);
`endif
    bus.rq_valid = 2'b00;
    tick();

    // Second simultaneous pair: requester 1 wins now.
    bus.rq_key0 = K2; bus.rq_key1 = K3; bus.rq_mode = 2'b11; bus.rq_valid = 2'b11;
    miss_flow("pair2_r1", K3);
    wait_grant("pair2_r1_grant", 2'b10);
    bus.rq_valid = 2'b01;
    tick();
    chk("pair2_r1_rel", bus.rq_grant, 0);
    miss_flow("pair2_r0", K2);
    wait_grant("pair2_r0_grant", 2'b01);
    bus.rq_valid = 2'b00;
    tick();

    // Reset during WAIT; a repeat of the last cached key must miss afterwards.
    bus.rq_key0 = K1; bus.rq_mode = 2'b01; bus.rq_valid = 2'b01;
    miss_flow("arst", K1);
    tick();
    #2 nrst = 1'b0;
    #1;
    chk("arst_grant", bus.rq_grant, 0);
    chk("arst_kx_nrst", bus.kx_nrst, 0);
    chk("arst_kx_valid", bus.kx_valid, 0);
    chk("arst_kx_key", bus.kx_key, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_count", cnt_a, 0);
    bus.rq_valid = 2'b00;
    tick(); tick();
    nrst = 1'b1;
    exp_cnt = 0;
    tick();
    bus.rq_key0 = K2; bus.rq_mode = 2'b01; bus.rq_valid = 2'b01;
    miss_flow("post_rst", K2);
    wait_grant("post_rst_grant", 2'b01);
    chk("post_rst_count", cnt_a, 1);
    bus.rq_valid = 2'b00;
    tick();

    // Saturation on the CNT_WIDTH=4 instance.
    for (int i = 0; i < 30; i++) begin
      bus_s.rq_key0 = (i % 2 == 0) ? K1 : K2;
      bus_s.rq_valid = 2'b01;
      for (int c = 0; c < 30 && bus_s.rq_grant == 2'b00; c++) tick();
      chk("sat_grant", bus_s.rq_grant, 2'b01);
      if (i == 13) chk("sat_count14", cnt_s, 4'd14);
      bus_s.rq_valid = 2'b00;
      tick();
    end
    chk("sat_count_final", cnt_s, 4'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
